jstk_spi_responder: RTL and testbench

- SPI mode-0 slave that reproduces the joystick module's side of the PmodJSTK link: it answers the 5-byte frame that the existing SPI master issues.
- Serves as the stand-in joystick for system simulation, and for FPGA loop-back with a scripted or keypad-driven stick.
- Takes parallel X/Y/button values and serialises them on MISO.
- Decodes the host command byte arriving on MOSI into the two LED bits.

---
 rtl/jstk_pkg.sv | 36 +++
 rtl/spi_sync_edge.sv | 31 +++
 rtl/jstk_spi_responder.sv | 122 ++++++++++++
 tb/tb_jstk_spi_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/jstk_pkg.sv
// Shared types and frame layout for the joystick SPI responder.
// The frame carries Y, X and buttons as five bytes, first byte on the wire in bits [39:32].
package jstk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [5:0] CMD_HDR    = 6'b100000;
    localparam int         FRAME_BITS = 40;

    // Byte slots within the frame register, counted from the least significant byte.
    localparam int Y_LO_BYTE = 4;
    localparam int Y_HI_BYTE = 3;
    localparam int X_LO_BYTE = 2;
    localparam int X_HI_BYTE = 1;
    localparam int BTN_BYTE  = 0;

    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] b
    );
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[Y_LO_BYTE*8 +: 8] = y[7:0];
        f[Y_HI_BYTE*8 +: 8] = {6'b0, y[9:8]};
        f[X_LO_BYTE*8 +: 8] = x[7:0];
        f[X_HI_BYTE*8 +: 8] = {6'b0, x[9:8]};
        f[BTN_BYTE*8  +: 8] = {5'b0, b};
        return f;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with registered rise/fall pulses; edge pulses appear STAGES+1 clk after the input.
// The sync output carries the same delay as the pulses, so data sampled on a pulse is coherent.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    // chain[STAGES] is the previous synchronised value, used for edge detection.
    logic [STAGES:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[STAGES-1:0], din};
            rise  <= chain[STAGES-1] & ~chain[STAGES];
            fall  <= ~chain[STAGES-1] & chain[STAGES];
        end
    end

    assign sync = chain[STAGES];

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave emulating the PmodJSTK: serialises a snapshot of X/Y/buttons on MISO and decodes the LED command.
// MISO updates SYNC_STAGES+2 clk after each SCLK fall; there is no backpressure, the master owns the pace.
module jstk_spi_responder #(
    parameter int         NUM_BYTES   = 5,
    parameter int         SYNC_STAGES = 2,
    parameter logic [5:0] CMD_HDR     = jstk_pkg::CMD_HDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCLK,
    input  logic       MOSI,
    input  logic       SS,
    output logic       MISO,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] btn,
    output logic [1:0] led,
    output logic       frame_done,
    output logic       frame_err,
    output logic       cmd_err
);

    import jstk_pkg::*;

    localparam logic [5:0] LAST_BIT = 6'(NUM_BYTES * 8);

    logic sclk_rise, sclk_fall, sclk_sync_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;
    logic ss_rise, ss_fall, ss_sync_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
        .clk(clk), .rst(rst), .din(SCLK),
        .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
        .clk(clk), .rst(rst), .din(MOSI),
        .sync(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss (
        .clk(clk), .rst(rst), .din(SS),
        .sync(ss_sync_unused), .rise(ss_rise), .fall(ss_fall)
    );

    state_t                state;
    logic [FRAME_BITS-1:0] tx;
    logic [FRAME_BITS-1:0] frame_now;
    logic [7:0]            rx;
    logic [7:0]            cmd_next;
    logic [5:0]            bit_cnt;
    logic                  overrun;

    assign frame_now = build_frame(x_pos, y_pos, btn);
    assign cmd_next  = {rx[6:0], mosi_s};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            tx         <= '0;
            rx         <= '0;
            bit_cnt    <= '0;
            overrun    <= 1'b0;
            MISO       <= 1'b0;
            led        <= 2'b00;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            cmd_err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    MISO <= 1'b0;
                    if (ss_fall) begin
                        tx      <= frame_now;
                        MISO    <= frame_now[FRAME_BITS-1];
                        rx      <= '0;
                        bit_cnt <= '0;
                        overrun <= 1'b0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // A same-cycle SCLK edge is dropped when SS rises.
                    if (ss_rise) begin
                        frame_err <= 1'b1;
                        MISO      <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (sclk_rise) begin
                        rx      <= cmd_next;
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd7) begin
                            if (cmd_next[7:2] == CMD_HDR) led <= cmd_next[1:0];
                            else                          cmd_err <= 1'b1;
                        end
                        if (bit_cnt == LAST_BIT - 6'd1) begin
                            MISO  <= 1'b0;
                            state <= ST_HOLD;
                        end
                    end else if (sclk_fall) begin
                        tx   <= {tx[FRAME_BITS-2:0], 1'b0};
                        MISO <= tx[FRAME_BITS-2];
                    end
                end
                ST_HOLD: begin
                    MISO <= 1'b0;
                    if (ss_rise) begin
                        frame_done <= ~overrun;
                        frame_err  <= overrun;
                        state      <= ST_IDLE;
                    end else if (sclk_rise) begin
                        overrun <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Self-checking bench: a bit-banged SPI master drives frames and compares against a byte-level joystick model.
module tb_jstk_spi_responder;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SCLK = 1'b0;
    logic       MOSI = 1'b0;
    logic       SS = 1'b1;
    logic       MISO;
    logic [9:0] x_pos = '0;
    logic [9:0] y_pos = '0;
    logic [2:0] btn = '0;
    logic [1:0] led;
    logic       frame_done, frame_err, cmd_err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done = 0, n_ferr = 0, n_cerr = 0;
    logic [1:0] model_led = 2'b00;

    jstk_spi_responder dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(MISO),
        .x_pos(x_pos), .y_pos(y_pos), .btn(btn), .led(led),
        .frame_done(frame_done), .frame_err(frame_err), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) n_done++;
        if (frame_err)  n_ferr++;
        if (cmd_err)    n_cerr++;
    end

    // Reference: the five bytes as the joystick sends them, first byte most significant.
    function automatic logic [39:0] expect_frame(input int x, input int y, input int b);
        logic [7:0] b0, b1, b2, b3, b4;
        b0 = 8'(y % 256);
        b1 = 8'(y / 256);
        b2 = 8'(x % 256);
        b3 = 8'(x / 256);
        b4 = 8'(b);
        return {b0, b1, b2, b3, b4};
    endfunction

    function automatic logic [1:0] expect_led(input logic [1:0] cur, input int cmd);
        if (cmd / 4 == 32) return 2'(cmd % 4);
        return cur;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode-0 master: n_rises SCLK pulses, optional x change at bit 20, optional reset at bit rst_at.
    task automatic spi_frame(input logic [7:0] cmd, input int n_rises,
                             input bit chg, input logic [9:0] new_x, input int rst_at,
                             output logic [39:0] dout, output logic [1:0] led8,
                             output logic miso41, output logic miso_rst, output logic [1:0] led_rst);
        dout = '0; led8 = 'x; miso41 = 1'b0; miso_rst = 1'bx; led_rst = 'x;
        SS = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < n_rises; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                #1;
                miso_rst = MISO;
                led_rst  = led;
                wait_clk(2);
                rst = 1'b0;
            end
            if (chg && i == 20) x_pos = new_x;
            MOSI = (i < 8) ? cmd[7-i] : 1'b0;
            wait_clk(HALF);
            SCLK = 1'b1;
            if (i < 40) dout[39-i] = MISO;
            else if (i == 40) miso41 = MISO;
            wait_clk(HALF);
            if (i == 7) led8 = led;
            SCLK = 1'b0;
        end
        wait_clk(HALF);
        SS = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(6);
        n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso got %b want 0", MISO); end
        n_checks++; if (led !== 2'b00) begin n_fail++; $display("FAIL reset_led got %b want 00", led); end
        n_checks++; if (n_done + n_ferr + n_cerr !== 0) begin
            n_fail++; $display("FAIL reset_pulses got %0d want 0", n_done + n_ferr + n_cerr); end
    endtask

    task automatic test_basic;
        logic [39:0] d; logic [1:0] l8, lr; logic m41, mr;
        int d0, e0, c0;
        x_pos = 10'h2A5; y_pos = 10'h1F0; btn = 3'b101;
        d0 = n_done; e0 = n_ferr; c0 = n_cerr;
        spi_frame(8'h83, 40, 0, '0, -1, d, l8, m41, mr, lr);
        model_led = expect_led(model_led, 8'h83);
        n_checks++; if (d !== 40'hF0_01_A5_02_05) begin n_fail++; $display("FAIL basic_dout got %h want F001A50205", d); end
        n_checks++; if (l8 !== 2'b11) begin n_fail++; $display("FAIL basic_led8 got %b want 11", l8); end
        n_checks++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL basic_done got %0d want 1", n_done - d0); end
        n_checks++; if (n_ferr - e0 !== 0) begin n_fail++; $display("FAIL basic_ferr got %0d want 0", n_ferr - e0); end
        n_checks++; if (n_cerr - c0 !== 0) begin n_fail++; $display("FAIL basic_cerr got %0d want 0", n_cerr - c0); end
    endtask

    task automatic test_mid_change;
        logic [39:0] d, exp; logic [1:0] l8, lr; logic m41, mr;
        x_pos = 10'd512; y_pos = 10'd300; btn = 3'b010;
        exp = expect_frame(512, 300, 2);
        spi_frame(8'h83, 40, 1, 10'd700, -1, d, l8, m41, mr, lr);
        n_checks++; if (d !== exp) begin n_fail++; $display("FAIL midchg_snapshot got %h want %h", d, exp); end
        exp = expect_frame(700, 300, 2);
        spi_frame(8'h83, 40, 0, '0, -1, d, l8, m41, mr, lr);
        n_checks++; if (d !== exp) begin n_fail++; $display("FAIL midchg_next got %h want %h", d, exp); end
    endtask

    task automatic test_bad_cmd;
        logic [39:0] d, exp; logic [1:0] l8, lr; logic m41, mr;
        int d0, c0;
        x_pos = 10'h155; y_pos = 10'h3AA; btn = 3'b111;
        exp = expect_frame(10'h155, 10'h3AA, 7);
        d0 = n_done; c0 = n_cerr;
        spi_frame(8'h43, 40, 0, '0, -1, d, l8, m41, mr, lr);
        model_led = expect_led(model_led, 8'h43);
        n_checks++; if (n_cerr - c0 !== 1) begin n_fail++; $display("FAIL badcmd_cerr got %0d want 1", n_cerr - c0); end
        n_checks++; if (led !== model_led) begin n_fail++; $display("FAIL badcmd_led got %b want %b", led, model_led); end
        n_checks++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL badcmd_done got %0d want 1", n_done - d0); end
        n_checks++; if (d !== exp) begin n_fail++; $display("FAIL badcmd_dout got %h want %h", d, exp); end
    endtask

    task automatic test_abort;
        logic [39:0] d, exp; logic [1:0] l8, lr; logic m41, mr;
        int d0, e0;
        x_pos = 10'd77; y_pos = 10'd901; btn = 3'b001;
        d0 = n_done; e0 = n_ferr;
        spi_frame(8'h81, 20, 0, '0, -1, d, l8, m41, mr, lr);
        model_led = expect_led(model_led, 8'h81);
        n_checks++; if (n_ferr - e0 !== 1) begin n_fail++; $display("FAIL abort_ferr got %0d want 1", n_ferr - e0); end
        n_checks++; if (n_done - d0 !== 0) begin n_fail++; $display("FAIL abort_done got %0d want 0", n_done - d0); end
        n_checks++; if (led !== model_led) begin n_fail++; $display("FAIL abort_led got %b want %b", led, model_led); end
        exp = expect_frame(77, 901, 1);
        spi_frame(8'h82, 40, 0, '0, -1, d, l8, m41, mr, lr);
        model_led = expect_led(model_led, 8'h82);
        n_checks++; if (d !== exp) begin n_fail++; $display("FAIL abort_next got %h want %h", d, exp); end
    endtask

    task automatic test_overrun;
        logic [39:0] d, exp; logic [1:0] l8, lr; logic m41, mr;
        int d0, e0;
        x_pos = 10'h3FF; y_pos = 10'h3FF; btn = 3'b111;
        exp = expect_frame(1023, 1023, 7);
        d0 = n_done; e0 = n_ferr;
        spi_frame(8'h80, 41, 0, '0, -1, d, l8, m41, mr, lr);
        model_led = expect_led(model_led, 8'h80);
        n_checks++; if (d !== exp) begin n_fail++; $display("FAIL overrun_dout got %h want %h", d, exp); end
        n_checks++; if (m41 !== 1'b0) begin n_fail++; $display("FAIL overrun_bit41 got %b want 0", m41); end
        n_checks++; if (n_ferr - e0 !== 1) begin n_fail++; $display("FAIL overrun_ferr got %0d want 1", n_ferr - e0); end
        n_checks++; if (n_done - d0 !== 0) begin n_fail++; $display("FAIL overrun_done got %0d want 0", n_done - d0); end
    endtask

    task automatic test_reset_mid_frame;
        logic [39:0] d, exp; logic [1:0] l8, lr; logic m41, mr;
        int d0, e0;
        x_pos = 10'h2FF; y_pos = 10'h3FF; btn = 3'b110;
        exp = expect_frame(10'h2FF, 10'h3FF, 6);
        d0 = n_done; e0 = n_ferr;
        spi_frame(8'h83, 40, 0, '0, 17, d, l8, m41, mr, lr);
        model_led = 2'b00;
        n_checks++; if (mr !== 1'b0) begin n_fail++; $display("FAIL rstmid_miso got %b want 0", mr); end
        n_checks++; if (lr !== 2'b00) begin n_fail++; $display("FAIL rstmid_led got %b want 00", lr); end
        n_checks++; if (d[39:23] !== exp[39:23]) begin
            n_fail++; $display("FAIL rstmid_head got %h want %h", d[39:23], exp[39:23]); end
        n_checks++; if (d[22:0] !== 23'd0) begin n_fail++; $display("FAIL rstmid_tail got %h want 0", d[22:0]); end
        n_checks++; if (n_done - d0 + n_ferr - e0 !== 0) begin
            n_fail++; $display("FAIL rstmid_pulses got %0d want 0", n_done - d0 + n_ferr - e0); end
        x_pos = 10'd12; y_pos = 10'd640; btn = 3'b011;
        exp = expect_frame(12, 640, 3);
        spi_frame(8'h82, 40, 0, '0, -1, d, l8, m41, mr, lr);
        model_led = expect_led(model_led, 8'h82);
        n_checks++; if (d !== exp) begin n_fail++; $display("FAIL rstmid_next got %h want %h", d, exp); end
        n_checks++; if (led !== model_led) begin n_fail++; $display("FAIL rstmid_nextled got %b want %b", led, model_led); end
    endtask

    task automatic test_random;
        logic [39:0] d, exp; logic [1:0] l8, lr; logic m41, mr;
        int x, y, b, cmd, d0, c0, exp_c;
        for (int k = 0; k < 8; k++) begin
            x = $urandom_range(0, 1023);
            y = $urandom_range(0, 1023);
            b = $urandom_range(0, 7);
            cmd = $urandom_range(0, 255);
            if ($urandom_range(0, 1) == 1) cmd = 128 + (cmd % 4);
            x_pos = 10'(x); y_pos = 10'(y); btn = 3'(b);
            exp = expect_frame(x, y, b);
            exp_c = (cmd / 4 == 32) ? 0 : 1;
            d0 = n_done; c0 = n_cerr;
            spi_frame(8'(cmd), 40, 0, '0, -1, d, l8, m41, mr, lr);
            model_led = expect_led(model_led, cmd);
            n_checks++; if (d !== exp) begin n_fail++; $display("FAIL rand%0d_dout got %h want %h", k, d, exp); end
            n_checks++; if (led !== model_led) begin n_fail++; $display("FAIL rand%0d_led got %b want %b", k, led, model_led); end
            n_checks++; if (n_cerr - c0 !== exp_c) begin
                n_fail++; $display("FAIL rand%0d_cerr got %0d want %0d", k, n_cerr - c0, exp_c); end
            n_checks++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL rand%0d_done got %0d want 1", k, n_done - d0); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_mid_change;
        test_bad_cmd;
        test_abort;
        test_overrun;
        test_reset_mid_frame;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
